ad_sample_writer: RTL and testbench

- Acquisition-side responder to the Ethernet sample path.
- Serves the AD-capture handshake (ad_sample_req/ack + sample_len) by capturing 8-bit ADC samples into an internal buffer.
- Serves the packet-read handshake (read_req/ack) by pushing one chunk of 16-bit words per request into the TX FIFO.
- The MAC controller drains that FIFO.

---
 rtl/ad_sample_writer.sv | 207 ++++++++++++++++++++
 tb/tb_ad_sample_writer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad_sample_writer.sv
// Captures ADC samples into an internal buffer on request and streams them out
// as 16-bit words into the TX FIFO in CHUNK-sized bursts, one burst per read request.
module ad_sample_writer #(
   parameter int DEPTH     = 4096,
   parameter int CHUNK     = 512,
   parameter bit DATA_SIGN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  adc_data,
   input  logic        adc_valid,
   input  logic        ad_sample_req,
   output logic        ad_sample_ack,
   input  logic [31:0] sample_len,
   input  logic        read_req,
   output logic        read_req_ack,
   input  logic        fifo_full,
   output logic        fifo_wr_en,
   output logic [15:0] fifo_wr_data,
   output logic        busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
   localparam logic [LW-1:0] CHUNK_L = LW'(CHUNK);
   localparam logic [LW-1:0] ZERO_L  = '0;
   localparam logic [LW-1:0] ONE_L   = LW'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SAMPLE  = 2'd1,
      WAIT_RD = 2'd2,
      PUSH    = 2'd3
   } state_t;

   state_t state_r, state_s;

   logic [15:0]   mem_r [DEPTH];
   logic [15:0]   mem_q_r, out_r;
   logic [LW-1:0] len_r, remain_r, n_r, fetch_left_r;
   logic [AW-1:0] wr_ptr_r, rd_ptr_r;
   logic          mem_q_valid_r, out_valid_r;
   logic          sample_ack_r, read_ack_r, busy_r;

   logic [LW-1:0] len_clamp_s, chunk_s;
   logic          cap_accept_s, read_accept_s, sample_wr_s, last_sample_s;
   logic          accept_s, load_out_s, rd_en_s;

   function automatic logic [15:0] conv_sample(input logic [7:0] code);
      logic [7:0] s;
      s = {~code[7], code[6:0]};
      if (DATA_SIGN) begin
         conv_sample = {{8{s[7]}}, s};
      end else begin
         conv_sample = {8'h00, code};
      end
   endfunction

   // Length clamp and chunk size selection
   always_comb begin
      len_clamp_s = ZERO_L;
      chunk_s     = ZERO_L;
      if (sample_len > 32'(DEPTH)) begin
         len_clamp_s = DEPTH_L;
      end else begin
         len_clamp_s = sample_len[LW-1:0];
      end
      if (32'(remain_r) > 32'(CHUNK)) begin
         chunk_s = CHUNK_L;
      end else begin
         chunk_s = remain_r;
      end
   end

   // Next-state logic and handshake/datapath strobes
   always_comb begin
      state_s       = state_r;
      cap_accept_s  = 1'b0;
      read_accept_s = 1'b0;
      sample_wr_s   = 1'b0;
      last_sample_s = 1'b0;
      rd_en_s       = 1'b0;
      accept_s      = out_valid_r & ~fifo_full;
      load_out_s    = mem_q_valid_r & (~out_valid_r | accept_s);
      case (state_r)
         IDLE: begin
            // the ack register guard stops a still-held request being taken twice
            if (ad_sample_req && !sample_ack_r) begin
               cap_accept_s = 1'b1;
               if (len_clamp_s == ZERO_L) begin
                  state_s = IDLE;
               end else begin
                  state_s = SAMPLE;
               end
            end else begin
               state_s = IDLE;
            end
         end
         SAMPLE: begin
            if (adc_valid) begin
               sample_wr_s = 1'b1;
               if ({1'b0, wr_ptr_r} == len_r - ONE_L) begin
                  last_sample_s = 1'b1;
                  state_s       = WAIT_RD;
               end else begin
                  state_s = SAMPLE;
               end
            end else begin
               state_s = SAMPLE;
            end
         end
         WAIT_RD: begin
            if (read_req && !read_ack_r) begin
               read_accept_s = 1'b1;
               state_s       = PUSH;
            end else begin
               state_s = WAIT_RD;
            end
         end
         PUSH: begin
            rd_en_s = (fetch_left_r != ZERO_L) & (~mem_q_valid_r | load_out_s);
            if (accept_s && (n_r == ONE_L)) begin
               if (remain_r == ONE_L) begin
                  state_s = IDLE;
               end else begin
                  state_s = WAIT_RD;
               end
            end else begin
               state_s = PUSH;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, counters, handshake pulses and the output word register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= IDLE;
         sample_ack_r  <= 1'b0;
         read_ack_r    <= 1'b0;
         busy_r        <= 1'b0;
         len_r         <= ZERO_L;
         remain_r      <= ZERO_L;
         n_r           <= ZERO_L;
         fetch_left_r  <= ZERO_L;
         wr_ptr_r      <= '0;
         rd_ptr_r      <= '0;
         mem_q_valid_r <= 1'b0;
         out_valid_r   <= 1'b0;
         out_r         <= 16'h0000;
      end else begin
         state_r      <= state_s;
         sample_ack_r <= cap_accept_s;
         read_ack_r   <= read_accept_s;
         busy_r       <= (state_s != IDLE);
         if (cap_accept_s) begin
            len_r    <= len_clamp_s;
            wr_ptr_r <= '0;
         end else if (sample_wr_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (last_sample_s) begin
            remain_r <= len_r;
         end else if (accept_s) begin
            remain_r <= remain_r - ONE_L;
         end
         if (last_sample_s) begin
            rd_ptr_r <= '0;
         end else if (rd_en_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         // fetch_left bounds prefetch to the current chunk
         if (read_accept_s) begin
            n_r          <= chunk_s;
            fetch_left_r <= chunk_s;
         end else begin
            if (accept_s) n_r <= n_r - ONE_L;
            if (rd_en_s) fetch_left_r <= fetch_left_r - ONE_L;
         end
         mem_q_valid_r <= (mem_q_valid_r & ~load_out_s) | rd_en_s;
         if (load_out_s) begin
            out_r       <= mem_q_r;
            out_valid_r <= 1'b1;
         end else if (accept_s) begin
            out_valid_r <= 1'b0;
         end
      end
   end

   // Sample buffer: converted write port, registered read port
   always_ff @(posedge clk) begin
      if (sample_wr_s) mem_r[wr_ptr_r] <= conv_sample(adc_data);
      if (rd_en_s) mem_q_r <= mem_r[rd_ptr_r];
   end

   assign ad_sample_ack = sample_ack_r;
   assign read_req_ack  = read_ack_r;
   assign busy          = busy_r;
   assign fifo_wr_data  = out_r;
   assign fifo_wr_en    = accept_s;

endmodule

// File: tb/tb_ad_sample_writer.sv
// Self-checking bench for ad_sample_writer: table vectors plus a scoreboard of
// expected FIFO words pushed as samples are driven.
module tb_ad_sample_writer;

   localparam int DEPTH = 4096;
   localparam int CHUNK = 512;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  adc_data = 8'h00;
   logic        adc_valid = 1'b0;
   logic        ad_sample_req = 1'b0;
   logic        ad_sample_ack;
   logic [31:0] sample_len = 32'd0;
   logic        read_req = 1'b0;
   logic        read_req_ack;
   logic        fifo_full = 1'b0;
   logic        fifo_wr_en;
   logic [15:0] fifo_wr_data;
   logic        busy;

   ad_sample_writer #(.DEPTH(DEPTH), .CHUNK(CHUNK), .DATA_SIGN(1'b1)) dut (
      .clk(clk), .rst(rst),
      .adc_data(adc_data), .adc_valid(adc_valid),
      .ad_sample_req(ad_sample_req), .ad_sample_ack(ad_sample_ack),
      .sample_len(sample_len),
      .read_req(read_req), .read_req_ack(read_req_ack),
      .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  code;
      logic [15:0] exp;
   } vec_t;

   int checks = 0;
   int errors = 0;
   int wr_cnt = 0;
   int early_ack = 0;
   bit stall_en = 1'b0;
   logic [15:0] exp_q[$];
   logic [7:0]  stim_codes[$];
   logic [15:0] stim_exps[$];
   vec_t vecs [6];

   // offset binary to signed: code 0x80 is zero
   function automatic logic [15:0] model_word(input logic [7:0] code);
      int v;
      v = int'(code) - 128;
      return 16'(v);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every FIFO write is compared against the next expected word
   always @(negedge clk) begin
      if (fifo_wr_en === 1'b1) begin
         wr_cnt++;
         check("no_wr_while_full", 32'(fifo_full), 32'd0);
         check("wr_only_when_busy", 32'(busy), 32'd1);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got %0h expected no write", fifo_wr_data);
         end else begin
            check("wr_data", 32'(fifo_wr_data), 32'(exp_q.pop_front()));
         end
      end
   end

   // Random backpressure when enabled
   always @(posedge clk) begin
      #1;
      fifo_full = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs();
      check("rst_sample_ack", 32'(ad_sample_ack), 32'd0);
      check("rst_read_ack", 32'(read_req_ack), 32'd0);
      check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
      check("rst_wr_data", 32'(fifo_wr_data), 32'h0000);
      check("rst_busy", 32'(busy), 32'd0);
   endtask

   task automatic start_capture(input int len);
      bit acked;
      acked = 1'b0;
      sample_len = 32'(len);
      ad_sample_req = 1'b1;
      for (int i = 0; i < 20 && !acked; i++) begin
         @(negedge clk);
         if (ad_sample_ack) acked = 1'b1;
      end
      check("sample_ack_seen", 32'(acked), 32'd1);
      tick();
      ad_sample_req = 1'b0;
      @(negedge clk);
      check("sample_ack_pulse", 32'(ad_sample_ack), 32'd0);
      check("busy_after_accept", 32'(busy), 32'(len != 0));
   endtask

   task automatic load_ramp(input int n);
      for (int i = 0; i < n; i++) begin
         stim_codes.push_back(8'(i));
         stim_exps.push_back(model_word(8'(i)));
      end
   endtask

   task automatic drive_samples(input bit gaps);
      int cyc;
      cyc = 0;
      while (stim_codes.size() > 0) begin
         tick();
         cyc++;
         if (read_req_ack) early_ack++;
         if (gaps && (cyc % 3) != 0) begin
            adc_valid = 1'b0;
            adc_data  = 8'($urandom);
         end else begin
            adc_data  = stim_codes.pop_front();
            adc_valid = 1'b1;
            exp_q.push_back(stim_exps.pop_front());
         end
      end
      tick();
      adc_valid = 1'b0;
   endtask

   task automatic read_chunks(input int total, input bit chk_lat, output int nacks);
      int got, want, start, lat;
      bit acked;
      nacks = 0;
      got = 0;
      while (got < total) begin
         want = (total - got > CHUNK) ? CHUNK : total - got;
         read_req = 1'b1;
         acked = 1'b0;
         for (int i = 0; i < 50 && !acked; i++) begin
            @(negedge clk);
            if (read_req_ack) acked = 1'b1;
         end
         check("read_ack_seen", 32'(acked), 32'd1);
         read_req = 1'b0;
         if (!acked) break;
         nacks++;
         start = wr_cnt;
         lat = 0;
         while (!fifo_wr_en && lat < 3000) begin
            @(negedge clk);
            lat++;
         end
         if (chk_lat) check("first_wr_latency_le2", 32'(lat <= 2), 32'd1);
         for (int i = 0; i < 5000 && (wr_cnt - start) < want; i++) @(negedge clk);
         repeat (4) @(negedge clk);
         check("burst_len", 32'(wr_cnt - start), 32'(want));
         got += want;
      end
   endtask

   task automatic finish_txn(input string name, input int nacks, input int exp_acks);
      check({name, "_acks"}, 32'(nacks), 32'(exp_acks));
      check({name, "_busy_idle"}, 32'(busy), 32'd0);
      check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int nacks, start, acks_before;
      bit acked;

      vecs[0] = '{8'h00, 16'hFF80};
      vecs[1] = '{8'h80, 16'h0000};
      vecs[2] = '{8'hFF, 16'h007F};
      vecs[3] = '{8'h7F, 16'hFFFF};
      vecs[4] = '{8'h01, 16'hFF81};
      vecs[5] = '{8'hFE, 16'h007E};

      repeat (3) tick();
      @(negedge clk);
      check_reset_outputs();
      tick();
      rst = 1'b0;

      // conversion table
      for (int i = 0; i < 6; i++) begin
         stim_codes.push_back(vecs[i].code);
         stim_exps.push_back(vecs[i].exp);
      end
      start_capture(6);
      drive_samples(1'b0);
      read_chunks(6, 1'b1, nacks);
      finish_txn("table", nacks, 1);

      // chunking
      load_ramp(1100);
      start_capture(1100);
      drive_samples(1'b0);
      read_chunks(1100, 1'b1, nacks);
      finish_txn("chunk", nacks, 3);

      // backpressure
      load_ramp(1100);
      start_capture(1100);
      drive_samples(1'b0);
      stall_en = 1'b1;
      read_chunks(1100, 1'b0, nacks);
      stall_en = 1'b0;
      finish_txn("stall", nacks, 3);

      // clamp
      load_ramp(DEPTH);
      start_capture(10000);
      drive_samples(1'b0);
      read_chunks(DEPTH, 1'b1, nacks);
      finish_txn("clamp", nacks, DEPTH / CHUNK);

      // zero length: no capture, read_req ignored
      start_capture(0);
      acked = 1'b0;
      read_req = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (read_req_ack) acked = 1'b1;
      end
      read_req = 1'b0;
      check("zero_no_read_ack", 32'(acked), 32'd0);
      check("zero_busy", 32'(busy), 32'd0);

      // gapped capture with early read request
      for (int i = 0; i < 12; i++) begin
         stim_codes.push_back(8'($urandom));
         stim_exps.push_back(model_word(stim_codes[i]));
      end
      start_capture(12);
      read_req = 1'b1;
      early_ack = 0;
      drive_samples(1'b1);
      check("no_ack_during_sample", 32'(early_ack), 32'd0);
      read_chunks(12, 1'b1, nacks);
      finish_txn("gaps", nacks, 1);

      // reset in the middle of a burst
      load_ramp(300);
      start_capture(300);
      drive_samples(1'b0);
      read_req = 1'b1;
      acked = 1'b0;
      for (int i = 0; i < 50 && !acked; i++) begin
         @(negedge clk);
         if (read_req_ack) acked = 1'b1;
      end
      read_req = 1'b0;
      check("rstmid_read_ack", 32'(acked), 32'd1);
      start = wr_cnt;
      for (int i = 0; i < 2000 && (wr_cnt - start) < 100; i++) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs();
      exp_q.delete();
      repeat (2) tick();
      rst = 1'b0;
      acks_before = 0;
      read_req = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (read_req_ack) acks_before++;
      end
      read_req = 1'b0;
      check("post_rst_idle_no_ack", 32'(acks_before), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
      load_ramp(8);
      start_capture(8);
      drive_samples(1'b0);
      read_chunks(8, 1'b1, nacks);
      finish_txn("post_rst", nacks, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
